// File: rtl/spm_pkg.sv
// spm_pkg: shared constants for the serial-parallel multiplier.
// State encodings are plain localparams so legacy tools can consume them.
package spm_pkg;

   // Legal operand widths, checked when spm_seq elaborates.
   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 64;

   // Sequencer states.
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Counter width able to index all 2*width RUN cycles.
   function automatic int cnt_w(input int width);
      return $clog2(2 * width);
   endfunction

endpackage

// File: rtl/spm_cell.sv
// spm_cell: one carry-save bit cell of the serial-parallel multiplier chain.
// Holds a sum and a carry bit; clr has priority over en.
module spm_cell (
   input  logic clk,
   input  logic a,     // partial-product bit X[j] & ybit
   input  logic s_in,  // sum from the next-more-significant cell
   input  logic c_in,  // this cell's own carry, routed back by the parent
   input  logic clr,
   input  logic en,
   output logic s,
   output logic c
);

   // Full-add the three inputs into the sum/carry pair on each enabled edge.
   // NOTE: sequential state uses <= so every flop samples pre-edge values;
   // a blocking = here would let one flop see another's new value.
   always_ff @(posedge clk) begin
      if (clr) begin
         s <= 1'b0;
         c <= 1'b0;
      end else if (en) begin
         s <= a ^ s_in ^ c_in;
         c <= (a & s_in) | (a & c_in) | (s_in & c_in);
      end
   end

endmodule

// File: rtl/spm_seq.sv
// spm_seq: self-sequencing serial-parallel multiplier, WIDTH x WIDTH -> 2*WIDTH.
// The multiplier streams in LSB first through a chain of spm_cell instances;
// product bits leave cell 0 one per RUN cycle into a shift register.
// Define SPM_SIGNED_EN for two's-complement operands and product.
module spm_seq
   import spm_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   mc,
   input  logic [WIDTH-1:0]   mp,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] p
);

   localparam int            CW        = cnt_w(WIDTH);
   localparam int            PW        = 2 * WIDTH;
   localparam logic [CW-1:0] CNT_LAST  = CW'(PW - 1);
   localparam logic [CW-1:0] CNT_FLUSH = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("spm_seq: WIDTH out of range 2..64");
   end

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [PW-2:0]    prod_lo_q, prod_lo_d;
   logic [PW-1:0]    p_q, p_d;
   logic             done_q, done_d;

   logic             accept, run, ybit, cell_clr;
   logic [PW-1:0]    prod_w;
   logic [WIDTH-1:0] s_q, c_q, a_w, s_in_w;

`ifdef SPM_SIGNED_EN
   localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
   localparam logic [PW-1:0]    ONE_P = PW'(1);

   logic neg_q, neg_d;

   // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1).
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? (~v + ONE_W) : v;
   endfunction
`endif

   assign accept   = (state_q == IDLE) && start;
   assign run      = (state_q == RUN);
   assign ybit     = run && (cnt_q < CNT_FLUSH) && y_q[0];
   assign cell_clr = rst || accept;

   // The product MSB always equals cell 0's sum, since both load the same new
   // sum bit on every RUN edge; only the lower 2W-1 bits need their own flops.
   assign prod_w = {s_q[0], prod_lo_q};

   // Carry-save chain; the top cell sees s[WIDTH] = 0.
   for (genvar j = 0; j < WIDTH; j++) begin : g_cell
      assign a_w[j] = x_q[j] & ybit;
      if (j == WIDTH - 1) begin : g_top
         assign s_in_w[j] = 1'b0;
      end else begin : g_mid
         assign s_in_w[j] = s_q[j+1];
      end
      spm_cell u_cell (
         .clk  (clk),
         .a    (a_w[j]),
         .s_in (s_in_w[j]),
         .c_in (c_q[j]),
         .clr  (cell_clr),
         .en   (run),
         .s    (s_q[j]),
         .c    (c_q[j])
      );
   end

   // Next-state logic for the sequencer, operand registers and product.
   // NOTE: every variable gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      x_d       = x_q;
      y_d       = y_q;
      prod_lo_d = prod_lo_q;
      p_d       = p_q;
      done_d    = 1'b0;
`ifdef SPM_SIGNED_EN
      neg_d     = neg_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               cnt_d     = '0;
               prod_lo_d = '0;
`ifdef SPM_SIGNED_EN
               x_d       = mag(mc);
               y_d       = mag(mp);
               neg_d     = mc[WIDTH-1] ^ mp[WIDTH-1];
`else
               x_d       = mc;
               y_d       = mp;
`endif
            end
         end
         RUN: begin
            cnt_d     = cnt_q + CNT_ONE;
            y_d       = y_q >> 1;
            prod_lo_d = prod_w[PW-1:1];
            if (cnt_q == CNT_LAST) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
            done_d  = 1'b1;
`ifdef SPM_SIGNED_EN
            p_d     = neg_q ? (~prod_w + ONE_P) : prod_w;
`else
            p_d     = prod_w;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset; reset also aborts any operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         x_q       <= '0;
         y_q       <= '0;
         prod_lo_q <= '0;
         p_q       <= '0;
         done_q    <= 1'b0;
`ifdef SPM_SIGNED_EN
         neg_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         x_q       <= x_d;
         y_q       <= y_d;
         prod_lo_q <= prod_lo_d;
         p_q       <= p_d;
         done_q    <= done_d;
`ifdef SPM_SIGNED_EN
         neg_q     <= neg_d;
`endif
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign p    = p_q;

endmodule

// File: tb/tb_spm_seq.sv
// tb_spm_seq: self-checking bench for spm_seq at WIDTH=8 and WIDTH=32.
// Expectations follow SPM_SIGNED_EN when it is defined.
module tb_spm_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start8, busy8, done8;
   logic [7:0]  mc8, mp8;
   logic [15:0] p8;
   logic        start32, busy32, done32;
   logic [31:0] mc32, mp32;
   logic [63:0] p32;

   int n_pass  = 0;
   int n_total = 0;
   bit use_signed;

   typedef struct {
      logic [7:0]  mc;
      logic [7:0]  mp;
      logic [15:0] exp_u;
      logic [15:0] exp_s;
   } vec_t;

   spm_seq #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .mc(mc8), .mp(mp8),
      .busy(busy8), .done(done8), .p(p8)
   );

   spm_seq #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst(rst), .start(start32), .mc(mc32), .mp(mp32),
      .busy(busy32), .done(done32), .p(p32)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   // Reference products computed with plain integer arithmetic.
   function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
      int r;
`ifdef SPM_SIGNED_EN
      r = int'($signed(a)) * int'($signed(b));
`else
      r = int'(a) * int'(b);
`endif
      return r[15:0];
   endfunction

   function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b);
      longint r;
`ifdef SPM_SIGNED_EN
      r = longint'($signed(a)) * longint'($signed(b));
`else
      r = longint'(a) * longint'(b);
`endif
      return r[63:0];
   endfunction

   // Step edges until done8 is seen at a negedge or the budget runs out.
   task automatic wait8(inout int lat, inout int busy_cnt);
      while (lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (done8) break;
         if (busy8) busy_cnt++;
      end
   endtask

   // One 8-bit operation; inputs are scrambled during RUN. Returns at the done negedge.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, output int lat, output int busy_cnt);
      @(negedge clk);
      start8 = 1'b1; mc8 = a; mp8 = b;
      @(posedge clk);
      #1;
      start8 = 1'b0; mc8 = 8'($urandom); mp8 = 8'($urandom);
      lat = 0; busy_cnt = 0;
      @(negedge clk);
      if (busy8) busy_cnt++;
      wait8(lat, busy_cnt);
   endtask

   task automatic op32(input logic [31:0] a, input logic [31:0] b, output int lat);
      @(negedge clk);
      start32 = 1'b1; mc32 = a; mp32 = b;
      @(posedge clk);
      #1;
      start32 = 1'b0; mc32 = $urandom; mp32 = $urandom;
      lat = 0;
      while (lat < 300) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (done32) break;
      end
   endtask

   initial begin
      vec_t vecs[10];
      int   lat, bc, seen;
      logic [7:0]  ra, rb;
      logic [31:0] wa, wb;

`ifdef SPM_SIGNED_EN
      use_signed = 1'b1;
`else
      use_signed = 1'b0;
`endif
      vecs[0] = '{8'hFF, 8'hFF, 16'hFE01, 16'h0001};
      vecs[1] = '{8'h03, 8'h05, 16'h000F, 16'h000F};
      vecs[2] = '{8'h0C, 8'h0C, 16'h0090, 16'h0090};
      vecs[3] = '{8'hAB, 8'h00, 16'h0000, 16'h0000};
      vecs[4] = '{8'h80, 8'hFF, 16'h7F80, 16'h0080};
      vecs[5] = '{8'h05, 8'hFD, 16'h04F1, 16'hFFF1};
      vecs[6] = '{8'h80, 8'h80, 16'h4000, 16'h4000};
      vecs[7] = '{8'h00, 8'h00, 16'h0000, 16'h0000};
      vecs[8] = '{8'h01, 8'h7F, 16'h007F, 16'h007F};
      vecs[9] = '{8'h7F, 8'h80, 16'h3F80, 16'hC080};

      rst = 1'b1; start8 = 1'b0; mc8 = '0; mp8 = '0;
      start32 = 1'b0; mc32 = '0; mp32 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset busy8", 64'(busy8), 64'd0);
      check("reset done8", 64'(done8), 64'd0);
      check("reset p8", 64'(p8), 64'd0);
      check("reset busy32", 64'(busy32), 64'd0);
      check("reset done32", 64'(done32), 64'd0);
      check("reset p32", p32, 64'd0);
      rst = 1'b0;

      // Directed table.
      foreach (vecs[i]) begin
         op8(vecs[i].mc, vecs[i].mp, lat, bc);
         check($sformatf("vec%0d p", i), 64'(p8), 64'(use_signed ? vecs[i].exp_s : vecs[i].exp_u));
         check($sformatf("vec%0d latency", i), 64'(lat), 64'd17);
         check($sformatf("vec%0d busy at done", i), 64'(busy8), 64'd0);
         if (i == 0) check("vec0 busy cycles", 64'(bc), 64'd17);
         @(negedge clk);
         check($sformatf("vec%0d done one pulse", i), 64'(done8), 64'd0);
      end

      // WIDTH=32 full-range operand.
      op32(32'hFFFF_FFFF, 32'h0000_0002, lat);
      check("w32 p", p32, use_signed ? 64'hFFFF_FFFF_FFFF_FFFE : 64'h0000_0001_FFFF_FFFE);
      check("w32 latency", 64'(lat), 64'd65);
      @(negedge clk);
      check("w32 done one pulse", 64'(done32), 64'd0);

      // Start while busy is ignored; start in the done cycle is accepted.
      @(negedge clk);
      start8 = 1'b1; mc8 = 8'd3; mp8 = 8'd5;
      @(posedge clk);
      #1 start8 = 1'b0;
      lat = 0; bc = 0;
      repeat (5) begin @(posedge clk); lat++; end
      @(negedge clk);
      start8 = 1'b1; mc8 = 8'd7; mp8 = 8'd7;
      @(posedge clk);
      lat++;
      #1 start8 = 1'b0;
      @(negedge clk);
      wait8(lat, bc);
      check("busy-start p", 64'(p8), 64'h000F);
      check("busy-start latency", 64'(lat), 64'd17);
      start8 = 1'b1; mc8 = 8'd12; mp8 = 8'd12;
      @(posedge clk);
      #1 start8 = 1'b0;
      @(negedge clk);
      check("done-cycle start done drops", 64'(done8), 64'd0);
      check("done-cycle start accepted", 64'(busy8), 64'd1);
      check("p holds on start", 64'(p8), 64'h000F);
      lat = 0;
      wait8(lat, bc);
      check("done-cycle op p", 64'(p8), 64'h0090);
      check("done-cycle op latency", 64'(lat), 64'd17);
      seen = 0;
      repeat (25) begin @(negedge clk); if (done8) seen++; end
      check("no queued op", 64'(seen), 64'd0);

      // Reset in the middle of RUN aborts the operation.
      @(negedge clk);
      start8 = 1'b1; mc8 = 8'h55; mp8 = 8'h33;
      @(posedge clk);
      #1 start8 = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort busy", 64'(busy8), 64'd0);
      check("abort done", 64'(done8), 64'd0);
      check("abort p", 64'(p8), 64'd0);
      seen = 0;
      repeat (30) begin @(negedge clk); if (done8) seen++; end
      check("abort no done", 64'(seen), 64'd0);
      op8(8'hAB, 8'h00, lat, bc);
      check("zero op p", 64'(p8), 64'd0);
      check("zero op latency", 64'(lat), 64'd17);
      repeat (5) @(negedge clk);
      check("p holds between ops", 64'(p8), 64'd0);

      // Random operands against the reference model.
      repeat (40) begin
         ra = 8'($urandom); rb = 8'($urandom);
         op8(ra, rb, lat, bc);
         check($sformatf("rand8 %h*%h", ra, rb), 64'(p8), 64'(ref8(ra, rb)));
         check("rand8 latency", 64'(lat), 64'd17);
      end
      repeat (6) begin
         wa = $urandom; wb = $urandom;
         op32(wa, wb, lat);
         check($sformatf("rand32 %h*%h", wa, wb), p32, ref32(wa, wb));
         check("rand32 latency", 64'(lat), 64'd65);
      end
      op32(32'h8000_0000, 32'h8000_0000, lat);
      check("w32 min*min", p32, ref32(32'h8000_0000, 32'h8000_0000));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
